// File: rtl/accum_burst_ctrl_pkg.sv
// Shared definitions for the accumulator burst sequencer and its datapath:
// default widths and the sequencer state encoding.
package accum_burst_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LEN_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t CLEAR = 2'd1;
  localparam state_t ACCUM = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/accum_burst_ctrl_if.sv
// Command, operand and result handshakes of the burst sequencer.
// master = command/operand source and result sink; slave = the sequencer.
interface accum_burst_ctrl_if
  import accum_burst_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  modport master (
    output cmd_valid, cmd_len, in_valid, in_data, res_ready,
    input  cmd_ready, in_ready, res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, in_valid, in_data, res_ready,
    output cmd_ready, in_ready, res_valid, res_data, busy
  );

endinterface

// File: rtl/accum_burst_ctrl_accumulator.sv
// Plain wrapping accumulator: adds in to sum when en is high; synchronous
// active-high rst (also used as the per-burst clear) zeroes the sum.
module accumulator
  import accum_burst_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] sum
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)     sum <= '0;
    else if (en) sum <= sum + in;
  end

endmodule

// File: rtl/accum_burst_ctrl.sv
// Burst sequencer: accepts a command, clears the accumulator, feeds it exactly
// cmd_len operands, then holds the sum on the result handshake until taken.
module accum_burst_ctrl
  import accum_burst_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  accum_burst_ctrl_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] count;
  logic             clear;
  logic             beat;
  logic [WIDTH-1:0] sum;

  assign clear = (state == CLEAR);
  assign beat  = (state == ACCUM) && bus.in_valid;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = CLEAR;
      CLEAR:   state_nxt = (count != '0) ? ACCUM : DONE;
      ACCUM:   if (beat && count == LEN_W'(1)) state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.cmd_valid) count <= bus.cmd_len;
      else if (beat)                      count <= count - LEN_W'(1);
    end
  end

  // The clear strobe reuses the datapath reset, so a new burst never sees old sum.
  accumulator #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk (clk),
    .rst (rst | clear),
    .en  (beat),
    .in  (bus.in_data),
    .sum (sum)
  );

  // Handshake outputs decode state only; res_data is the registered sum.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.in_ready  = (state == ACCUM);
  assign bus.res_valid = (state == DONE);
  assign bus.res_data  = sum;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_accum_burst_ctrl.sv
// Self-checking bench for accum_burst_ctrl: directed vector table, hand-written
// reset and back-to-back sequences, and random bursts against a sum/latency model.
module tb_accum_burst_ctrl;
  import accum_burst_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accum_burst_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  accum_burst_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] burst_ops [256];

  typedef struct {
    int             len;
    int             gap;       // idle in_valid cycles between beats
    int             hold;      // cycles res_ready stays low in DONE
    bit             stray;     // drive in_valid high outside ACCUM
    bit             hold_cmd;  // keep cmd_valid high through the burst
    logic [7:0][7:0] ops;      // operand i uses byte i % 8
    int             exp_sum;
    int             exp_lat;   // cycles from accept edge to res_valid
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_burst(input string tag, input int len, input int gap, input int hold,
                           input bit stray, input bit hold_cmd, input int exp_sum,
                           input int exp_lat);
    int k, beats, idx, gap_ctr;
    bit ir_bad, cr_bad, unstable;
    logic [WIDTH-1:0] held;
    beats = 0; idx = 0; gap_ctr = 0; ir_bad = 0; cr_bad = 0; unstable = 0;

    check({tag, "_cmd_ready_idle"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len[LEN_W-1:0];
    step();
    bus.cmd_valid = hold_cmd;
    check({tag, "_accepted_busy"}, bus.busy, 1);

    k = 1;
    while (!bus.res_valid && k < len * (gap + 1) + 20) begin
      if (bus.cmd_ready) cr_bad = 1;
      if (bus.in_ready !== (k >= 2)) ir_bad = 1;
      if (bus.in_ready) begin
        if (gap_ctr > 0) begin
          bus.in_valid = 1'b0;
          gap_ctr--;
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = burst_ops[idx & 255];
          beats++;
          idx++;
          gap_ctr = gap;
        end
      end else begin
        bus.in_valid = stray;
        bus.in_data  = 8'($urandom);
      end
      step();
      k++;
    end

    check({tag, "_res_valid"}, bus.res_valid, 1);
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_beats"}, beats, len);
    check({tag, "_res_data"}, bus.res_data, exp_sum);
    check({tag, "_in_ready_window"}, ir_bad, 0);
    check({tag, "_no_cmd_while_busy"}, cr_bad, 0);

    held = bus.res_data;
    for (int h = 0; h < hold; h++) begin
      bus.res_ready = 1'b0;
      bus.in_valid  = ~bus.in_valid;
      bus.in_data   = 8'($urandom);
      step();
      if (!bus.res_valid || bus.res_data !== held || bus.cmd_ready || bus.in_ready) unstable = 1;
    end
    check({tag, "_done_stable"}, unstable, 0);

    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b0;
    step();
    bus.res_ready = 1'b0;
    check({tag, "_after_res_valid"}, bus.res_valid, 0);
    check({tag, "_after_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_after_busy"}, bus.busy, 0);
  endtask

  initial begin
    int len, gap, hold, sum;
    int q[$];

    vecs[0] = '{4,   0, 0, 1'b0, 1'b0, 64'h00000000_04030201, 10,  6};
    vecs[1] = '{3,   2, 0, 1'b0, 1'b0, 64'h00000000_003264C8, 94,  9};
    vecs[2] = '{0,   0, 0, 1'b1, 1'b0, 64'h0,                 0,   2};
    vecs[3] = '{2,   0, 5, 1'b1, 1'b1, 64'h00000000_00002211, 51,  4};
    vecs[4] = '{1,   0, 1, 1'b0, 1'b0, 64'h00000000_000000FF, 255, 3};
    vecs[5] = '{2,   1, 2, 1'b1, 1'b0, 64'h00000000_00008080, 0,   5};
    vecs[6] = '{5,   0, 0, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 251, 7};
    vecs[7] = '{255, 0, 0, 1'b0, 1'b0, 64'h01010101_01010101, 255, 257};

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_res_valid", bus.res_valid, 0);
    check("reset_res_data", bus.res_data, 0);
    check("reset_busy", bus.busy, 0);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 256; i++) burst_ops[i] = vecs[v].ops[i % 8];
      run_burst($sformatf("vec%0d", v), vecs[v].len, vecs[v].gap, vecs[v].hold,
                vecs[v].stray, vecs[v].hold_cmd, vecs[v].exp_sum, vecs[v].exp_lat);
    end

    // Reset two beats into a five-operand burst, then a clean burst must start from zero.
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd5;
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("midrst_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    step();
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_in_ready_low", bus.in_ready, 0);
    burst_ops[0] = 8'd7;
    burst_ops[1] = 8'd8;
    run_burst("midrst_next", 2, 0, 0, 1'b0, 1'b0, 15, 4);

    // Second command waits with cmd_valid high; accepted the cycle after the handshake.
    burst_ops[0] = 8'd5;
    run_burst("b2b_first", 1, 0, 0, 1'b0, 1'b1, 5, 3);
    burst_ops[0] = 8'd1;
    burst_ops[1] = 8'd1;
    run_burst("b2b_second", 2, 0, 0, 1'b0, 1'b0, 2, 4);

    for (int r = 0; r < 25; r++) begin
      len  = $urandom_range(0, 12);
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      q.delete();
      for (int i = 0; i < len; i++) begin
        burst_ops[i] = 8'($urandom);
        q.push_back(int'(burst_ops[i]));
      end
      sum = 0;
      foreach (q[i]) sum += q[i];
      run_burst($sformatf("rnd%0d", r), len, gap, hold, 1'($urandom), 1'b0, sum % 256,
                (len == 0) ? 2 : len + 2 + gap * (len - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
